// File: rtl/deserializer_pkg.sv
// Shared types and sizing helpers for the deserializer.
package deserializer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } state_e;

  // Word counter width: max(1, clog2(n)).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deserializer_control.sv
// FSM, word counter and handshake decode for the deserializer.
// DESERIALIZER_OVERLAP_EN lets a new frame start in the cycle the old one leaves.
module deserializer_control
  import deserializer_pkg::*;
#(
  parameter int N_SAMPLES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_recv_val,
  input  logic                 i_send_rdy,
  output logic                 o_recv_rdy,
  output logic                 o_send_val,
  output logic [N_SAMPLES-1:0] o_wr_en
);

  localparam int CW = cnt_width(N_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            w_recv_xfer, w_send_xfer;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= FILL;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    o_recv_rdy  = 1'b0;
    o_send_val  = 1'b0;
    o_wr_en     = '0;
    w_recv_xfer = 1'b0;
    w_send_xfer = 1'b0;
    case (r_state)
      FILL: begin
        o_recv_rdy  = 1'b1;
        w_recv_xfer = i_recv_val;
        if (w_recv_xfer) begin
          o_wr_en = N_SAMPLES'(1) << r_count;
          if (r_count == LAST) begin
            w_count_nxt = '0;
            w_state_nxt = DONE;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      DONE: begin
        o_send_val  = 1'b1;
        w_send_xfer = i_send_rdy;
`ifdef DESERIALIZER_OVERLAP_EN
        o_recv_rdy  = i_send_rdy;
        w_recv_xfer = i_recv_val & i_send_rdy;
`endif
        if (w_send_xfer) begin
          w_state_nxt = FILL;
          w_count_nxt = '0;
`ifdef DESERIALIZER_OVERLAP_EN
          // Incoming word becomes slot 0 of the next frame.
          if (w_recv_xfer) begin
            o_wr_en = N_SAMPLES'(1);
            if (N_SAMPLES == 1) w_state_nxt = DONE;
            else                w_count_nxt = CW'(1);
          end
`endif
        end
      end
      default: begin
        w_state_nxt = FILL;
        w_count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel frame builder: N_SAMPLES words of BIT_WIDTH into one message.
// Optional macro DESERIALIZER_OVERLAP_EN removes the per-frame bubble cycle.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [BIT_WIDTH-1:0]           i_recv_msg,
  input  logic                           i_recv_val,
  output logic                           o_recv_rdy,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] o_send_msg,
  output logic                           o_send_val,
  input  logic                           i_send_rdy
);

  logic [N_SAMPLES-1:0] w_wr_en;
  logic [BIT_WIDTH-1:0] r_slot [N_SAMPLES];

  deserializer_control #(.N_SAMPLES(N_SAMPLES)) u_ctrl (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_recv_val (i_recv_val),
    .i_send_rdy (i_send_rdy),
    .o_recv_rdy (o_recv_rdy),
    .o_send_val (o_send_val),
    .o_wr_en    (w_wr_en)
  );

  // Slots keep their contents after a frame leaves; the next frame overwrites them.
  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_slot
    always_ff @(posedge i_clk) begin
      if (i_reset)         r_slot[i] <= '0;
      else if (w_wr_en[i]) r_slot[i] <= i_recv_msg;
    end
    assign o_send_msg[i*BIT_WIDTH +: BIT_WIDTH] = r_slot[i];
  end

endmodule
